// File: rtl/bp_fe_bp_gpredict_pkg.sv
// Shared types and helpers for the global-history branch predictor:
// FSM states, hash-mode selectors and the saturating counter update.
package bp_fe_bp_gpredict_pkg;

    typedef enum logic [0:0] {
        e_init  = 1'b0,
        e_ready = 1'b1
    } bp_gp_state_e;

    localparam int unsigned e_gselect = 32'd0;
    localparam int unsigned e_gshare  = 32'd1;

    // Saturating step of a width_i-bit counter carried in a 32-bit container
    function automatic logic [31:0] ctr_sat_update(
        input logic [31:0] ctr_i,
        input logic        taken_i,
        input int unsigned width_i
    );
        logic [31:0] max_v;
        max_v = (32'd1 << width_i) - 32'd1;
        if (taken_i) begin
            return (ctr_i >= max_v) ? max_v : (ctr_i + 32'd1);
        end else begin
            return (ctr_i == 32'd0) ? 32'd0 : (ctr_i - 32'd1);
        end
    endfunction

endpackage

// File: rtl/bp_fe_bp_gpredict_hash.sv
// Combinational table-index hash: gselect concatenates low PC bits with the
// history, gshare XORs the PC with the zero-extended history.
module bp_fe_bp_gpredict_hash
    import bp_fe_bp_gpredict_pkg::*;
#(
    parameter int unsigned bht_idx_width_p = 8,
    parameter int unsigned ghist_width_p   = 6,
    parameter int unsigned hash_mode_p     = e_gselect
) (
    input  logic [bht_idx_width_p-1:0] pc_i,
    input  logic [ghist_width_p-1:0]   ghist_i,
    output logic [bht_idx_width_p-1:0] idx_o
);

    if (hash_mode_p == e_gshare) begin : g_gshare
        assign idx_o = pc_i ^ bht_idx_width_p'(ghist_i);
    end else begin : g_gselect
        // High PC bits are displaced by the history in this mode
        logic unused_pc_hi_s;
        assign unused_pc_hi_s = ^pc_i[bht_idx_width_p-1:bht_idx_width_p-ghist_width_p];
        assign idx_o = {pc_i[bht_idx_width_p-ghist_width_p-1:0], ghist_i};
    end

endmodule

// File: rtl/bp_fe_bp_gpredict.sv
// Global-history branch predictor: speculative history shifted on predict and
// restored on mispredict, self-clearing table init and one-stage update pipe.
module bp_fe_bp_gpredict
    import bp_fe_bp_gpredict_pkg::*;
#(
    parameter int unsigned bht_idx_width_p = 8,
    parameter int unsigned ghist_width_p   = 6,
    parameter int unsigned ctr_width_p     = 2,
    parameter int unsigned hash_mode_p     = e_gselect
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    output logic                       init_done_o,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] pc_idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic [ghist_width_p-1:0]   predict_ghist_o,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] w_idx_i,
    input  logic [ghist_width_p-1:0]   w_ghist_i,
    input  logic                       w_taken_i,
    input  logic                       w_mispredict_i
);

    localparam int unsigned els_lp = 32'd1 << bht_idx_width_p;
    localparam logic [ctr_width_p-1:0] ctr_init_lp =
        ctr_width_p'((32'd1 << (ctr_width_p - 32'd1)) - 32'd1);

    bp_gp_state_e state_q, state_d;
    logic [bht_idx_width_p-1:0] init_cnt_q, init_cnt_d;
    logic [ghist_width_p-1:0]   ghist_q, ghist_d;
    logic [ctr_width_p-1:0]     mem_q [els_lp];

    logic                       predict_v_q, predict_v_d;
    logic                       predict_q, predict_d;
    logic [ghist_width_p-1:0]   predict_ghist_q, predict_ghist_d;

    logic                       upd_v_q, upd_v_d;
    logic [bht_idx_width_p-1:0] upd_idx_q, upd_idx_d;
    logic [ghist_width_p-1:0]   upd_ghist_q, upd_ghist_d;
    logic                       upd_taken_q, upd_taken_d;

    logic                       ready_s;
    logic                       restore_s;
    logic [bht_idx_width_p-1:0] rd_idx_s;
    logic [bht_idx_width_p-1:0] upd_hash_idx_s;
    logic                       rd_taken_s;
    logic [ctr_width_p-1:0]     upd_ctr_new_s;
    logic                       mem_we_s;
    logic [bht_idx_width_p-1:0] mem_waddr_s;
    logic [ctr_width_p-1:0]     mem_wdata_s;

    bp_fe_bp_gpredict_hash #(
        .bht_idx_width_p(bht_idx_width_p),
        .ghist_width_p  (ghist_width_p),
        .hash_mode_p    (hash_mode_p)
    ) u_rd_hash (
        .pc_i   (pc_idx_r_i),
        .ghist_i(ghist_q),
        .idx_o  (rd_idx_s)
    );

    bp_fe_bp_gpredict_hash #(
        .bht_idx_width_p(bht_idx_width_p),
        .ghist_width_p  (ghist_width_p),
        .hash_mode_p    (hash_mode_p)
    ) u_upd_hash (
        .pc_i   (upd_idx_q),
        .ghist_i(upd_ghist_q),
        .idx_o  (upd_hash_idx_s)
    );

    assign ready_s    = (state_q == e_ready);
    assign restore_s  = ready_s & w_v_i & w_mispredict_i;
    assign rd_taken_s = mem_q[rd_idx_s][ctr_width_p-1];

    // Init FSM: sweep every entry once, then stay ready until reset
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            e_init: begin
                init_cnt_d = init_cnt_q + bht_idx_width_p'(1);
                if (init_cnt_q == {bht_idx_width_p{1'b1}}) begin
                    state_d = e_ready;
                end else begin
                    state_d = e_init;
                end
            end
            e_ready: state_d = e_ready;
            default: state_d = e_init;
        endcase
    end

    // Prediction outputs and speculative history; a restore beats the shift
    always_comb begin
        predict_v_d     = 1'b0;
        predict_d       = 1'b0;
        predict_ghist_d = '0;
        ghist_d         = ghist_q;
        if (ready_s & r_v_i) begin
            predict_v_d     = 1'b1;
            predict_d       = rd_taken_s;
            predict_ghist_d = ghist_q;
        end else begin
            predict_v_d     = 1'b0;
            predict_d       = 1'b0;
            predict_ghist_d = '0;
        end
        if (restore_s) begin
            ghist_d = ghist_width_p'({w_ghist_i, w_taken_i});
        end else if (ready_s & r_v_i) begin
            ghist_d = ghist_width_p'({ghist_q, rd_taken_s});
        end else begin
            ghist_d = ghist_q;
        end
    end

    // Update stage 0 capture; resolved branches are ignored until ready
    always_comb begin
        upd_v_d     = ready_s & w_v_i;
        upd_idx_d   = w_idx_i;
        upd_ghist_d = w_ghist_i;
        upd_taken_d = w_taken_i;
    end

    // Single table write port shared by init sweep and update stage 1
    always_comb begin
        upd_ctr_new_s = ctr_width_p'(ctr_sat_update(32'(mem_q[upd_hash_idx_s]),
                                                    upd_taken_q, ctr_width_p));
        mem_we_s      = 1'b0;
        mem_waddr_s   = init_cnt_q;
        mem_wdata_s   = ctr_init_lp;
        if (!ready_s) begin
            mem_we_s    = reset_n_i;
            mem_waddr_s = init_cnt_q;
            mem_wdata_s = ctr_init_lp;
        end else begin
            mem_we_s    = reset_n_i & upd_v_q;
            mem_waddr_s = upd_hash_idx_s;
            mem_wdata_s = upd_ctr_new_s;
        end
    end

    // Control and pipeline registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q         <= e_init;
            init_cnt_q      <= '0;
            ghist_q         <= '0;
            predict_v_q     <= 1'b0;
            predict_q       <= 1'b0;
            predict_ghist_q <= '0;
            upd_v_q         <= 1'b0;
            upd_idx_q       <= '0;
            upd_ghist_q     <= '0;
            upd_taken_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            ghist_q         <= ghist_d;
            predict_v_q     <= predict_v_d;
            predict_q       <= predict_d;
            predict_ghist_q <= predict_ghist_d;
            upd_v_q         <= upd_v_d;
            upd_idx_q       <= upd_idx_d;
            upd_ghist_q     <= upd_ghist_d;
            upd_taken_q     <= upd_taken_d;
        end
    end

    // Counter table; contents are established by the init sweep
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign init_done_o     = ready_s;
    assign predict_v_o     = predict_v_q;
    assign predict_o       = predict_q;
    assign predict_ghist_o = predict_ghist_q;

endmodule

// File: tb/tb_bp_fe_bp_gpredict.sv
// Bench: gselect DUT (idx 4, hist 3) checked by directed table and a cycle
// reference model; gshare DUT (idx 4, hist 4) checked by a directed table.
module tb_bp_fe_bp_gpredict;

    localparam int AI = 4;
    localparam int AG = 3;
    localparam int AC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_rv, a_wv, a_wt, a_wm, a_done, a_pv, a_p;
    logic [3:0] a_pc, a_widx;
    logic [2:0] a_wg, a_pg;

    logic       b_rv, b_wv, b_wt, b_wm, b_done, b_pv, b_p;
    logic [3:0] b_pc, b_widx, b_wg, b_pg;

    bp_fe_bp_gpredict #(.bht_idx_width_p(4), .ghist_width_p(3), .ctr_width_p(2), .hash_mode_p(0)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .init_done_o(a_done),
        .r_v_i(a_rv), .pc_idx_r_i(a_pc),
        .predict_v_o(a_pv), .predict_o(a_p), .predict_ghist_o(a_pg),
        .w_v_i(a_wv), .w_idx_i(a_widx), .w_ghist_i(a_wg), .w_taken_i(a_wt), .w_mispredict_i(a_wm)
    );

    bp_fe_bp_gpredict #(.bht_idx_width_p(4), .ghist_width_p(4), .ctr_width_p(2), .hash_mode_p(1)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .init_done_o(b_done),
        .r_v_i(b_rv), .pc_idx_r_i(b_pc),
        .predict_v_o(b_pv), .predict_o(b_p), .predict_ghist_o(b_pg),
        .w_v_i(b_wv), .w_idx_i(b_widx), .w_ghist_i(b_wg), .w_taken_i(b_wt), .w_mispredict_i(b_wm)
    );

    typedef struct {
        bit rv; logic [3:0] pc;
        bit wv; logic [3:0] widx; logic [3:0] wg; bit wt; bit wm;
        bit ev; bit ep; logic [3:0] eg;
    } vec_t;

    vec_t ta[$];
    vec_t tb[$];

    int checks = 0;
    int errors = 0;

    int m_ctr[16];
    int m_gh, m_left, m_pidx;
    bit m_pv, m_pt;
    bit e_done, e_v, e_p;
    int e_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rv, int pc, bit wv, int widx, int wg, bit wt, bit wm,
                                bit ev, bit ep, int eg);
        vec_t v;
        v.rv = rv; v.pc = 4'(pc); v.wv = wv; v.widx = 4'(widx); v.wg = 4'(wg);
        v.wt = wt; v.wm = wm; v.ev = ev; v.ep = ep; v.eg = 4'(eg);
        return v;
    endfunction

    // gselect index with 4-bit table and 3-bit history: {pc[0], ghist}
    function automatic int hsel(int pc, int gh);
        return ((pc % (1 << (AI - AG))) << AG) | gh;
    endfunction

    task automatic model_edge();
        bit pred;
        int ix, wg, lim;
        lim = (1 << AC) - 1;
        if (!rst_n) begin
            m_left = 1 << AI;
            for (int i = 0; i < 16; i++) m_ctr[i] = (1 << (AC - 1)) - 1;
            m_gh = 0; m_pv = 0;
            e_done = 0; e_v = 0; e_p = 0; e_g = 0;
        end else if (m_left > 0) begin
            m_left--;
            e_done = (m_left == 0); e_v = 0; e_p = 0; e_g = 0;
        end else begin
            e_done = 1; pred = 0;
            if (a_rv) begin
                ix = hsel(int'(a_pc), m_gh);
                pred = (m_ctr[ix] >= (1 << (AC - 1)));
                e_v = 1; e_p = pred; e_g = m_gh;
            end else begin
                e_v = 0; e_p = 0; e_g = 0;
            end
            if (m_pv) begin
                if (m_pt) m_ctr[m_pidx] = (m_ctr[m_pidx] == lim) ? lim : m_ctr[m_pidx] + 1;
                else      m_ctr[m_pidx] = (m_ctr[m_pidx] == 0) ? 0 : m_ctr[m_pidx] - 1;
            end
            wg = int'(a_wg);
            m_pv = a_wv;
            if (a_wv) begin
                m_pidx = hsel(int'(a_widx), wg);
                m_pt = a_wt;
            end
            if (a_wv && a_wm) m_gh = ((wg << 1) | int'(a_wt)) % (1 << AG);
            else if (a_rv)    m_gh = ((m_gh << 1) | int'(pred)) % (1 << AG);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        chk("a_init_done", a_done, e_done);
        chk("a_predict_v", a_pv, e_v);
        chk("a_predict", a_p, e_p);
        chk("a_predict_ghist", a_pg, e_g);
    endtask

    task automatic set_a(input vec_t v);
        a_rv = v.rv; a_pc = v.pc; a_wv = v.wv; a_widx = v.widx;
        a_wg = v.wg[2:0]; a_wt = v.wt; a_wm = v.wm;
    endtask

    task automatic set_b(input vec_t v);
        b_rv = v.rv; b_pc = v.pc; b_wv = v.wv; b_widx = v.widx;
        b_wg = v.wg; b_wt = v.wt; b_wm = v.wm;
    endtask

    initial begin
        vec_t idle, busy;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        busy = mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);

        // Saturation, read-before-write, speculative history and recovery
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (3) ta.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        ta.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        repeat (5) ta.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        ta.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        ta.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        ta.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        ta.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        ta.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0, 0, 0));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 3));
        ta.push_back(mk(0, 0, 1, 0, 5, 0, 1, 0, 0, 0));
        ta.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        ta.push_back(mk(1, 0, 1, 0, 5, 0, 1, 1, 0, 4));
        ta.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 2));

        // gshare: every entry starts weakly not-taken, then entry 1100 trained
        for (int k = 0; k < 16; k++) tb.push_back(mk(1, k, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (2) tb.push_back(mk(0, 0, 1, 10, 6, 1, 0, 0, 0, 0));
        tb.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0, 0, 0));
        tb.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1, 1, 6));
        tb.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 13));

        rst_n = 1'b0;
        set_a(busy);
        set_b(busy);
        repeat (3) tick();
        chk("rst_init_done", a_done, 0);
        chk("rst_predict_v", a_pv, 0);
        chk("rst_b_init_done", b_done, 0);

        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("init_latency", a_done, (k == 16) ? 1 : 0);
            chk("init_b_latency", b_done, (k == 16) ? 1 : 0);
            chk("init_predict_v", a_pv, 0);
        end
        set_a(idle);
        set_b(idle);

        foreach (ta[i]) begin
            set_a(ta[i]);
            tick();
            chk("tblA_predict_v", a_pv, ta[i].ev);
            chk("tblA_predict", a_p, ta[i].ep);
            chk("tblA_ghist", a_pg, ta[i].eg);
        end
        set_a(idle);

        foreach (tb[i]) begin
            set_b(tb[i]);
            tick();
            chk("tblB_predict_v", b_pv, tb[i].ev);
            chk("tblB_predict", b_p, tb[i].ep);
            chk("tblB_ghist", b_pg, tb[i].eg);
        end
        set_b(idle);

        // Reset one cycle after an update is sampled
        set_a(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        tick();
        set_a(idle);
        rst_n = 1'b0;
        tick();
        chk("midrst_init_done", a_done, 0);
        chk("midrst_predict_v", a_pv, 0);
        chk("midrst_predict", a_p, 0);
        chk("midrst_ghist", a_pg, 0);
        rst_n = 1'b1;
        repeat (16) tick();
        chk("midrst_reinit_done", a_done, 1);
        set_a(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("midrst_predict_after", a_p, 0);
        chk("midrst_predict_v_after", a_pv, 1);

        for (int n = 0; n < 1200; n++) begin
            rst_n  = ($urandom_range(0, 399) != 0);
            a_rv   = 1'($urandom_range(0, 1));
            a_pc   = 4'($urandom);
            a_wv   = ($urandom_range(0, 2) == 0);
            a_widx = 4'($urandom);
            a_wg   = 3'($urandom);
            a_wt   = 1'($urandom_range(0, 1));
            a_wm   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
